// File: rtl/dram_host_initiator.sv
// Host-side initiator for a small synchronous DRAM array: single-beat read/write
// requests in, registered array pins out, read responses with backpressure, periodic refresh.
module dram_host_initiator #(
  parameter int ADDR_W         = 4,
  parameter int DATA_W         = 8,
  parameter int RD_LAT         = 1,
  parameter int REFRESH_PERIOD = 64,
  parameter int REFRESH_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              refresh_active
);

  localparam int RCNT_W = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  localparam int WCNT_W = 3;
  localparam int CCNT_W = $clog2(REFRESH_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RD_WAIT,
    S_RSP,
    S_REFRESH
  } state_t;

  state_t              state_q;
  logic [RCNT_W-1:0]   ref_cnt_q;
  logic                ref_pending_q;
  logic [WCNT_W-1:0]   wait_cnt_q;
  logic [CCNT_W-1:0]   ref_cyc_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                mem_we_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic                rsp_valid_q;
  logic                refresh_active_q;
  logic                ref_wrap_d;

  assign ref_wrap_d = (ref_cnt_q == RCNT_W'(REFRESH_PERIOD - 1));

  // A pending refresh closes the request port as soon as it is flagged.
  assign req_ready = !rst && (state_q == S_IDLE) && !ref_pending_q;

  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign mem_write_en   = mem_we_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_valid      = rsp_valid_q;
  assign refresh_active = refresh_active_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      ref_cnt_q        <= '0;
      ref_pending_q    <= 1'b0;
      wait_cnt_q       <= '0;
      ref_cyc_q        <= '0;
      mem_addr_q       <= '0;
      mem_wdata_q      <= '0;
      mem_we_q         <= 1'b0;
      rsp_data_q       <= '0;
      rsp_valid_q      <= 1'b0;
      refresh_active_q <= 1'b0;
    end else begin
      ref_cnt_q <= ref_wrap_d ? '0 : ref_cnt_q + 1'b1;
      if (ref_wrap_d) begin
        ref_pending_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (ref_pending_q) begin
            // Entering the window services the outstanding request; this clear wins over a same-edge wrap.
            state_q          <= S_REFRESH;
            ref_pending_q    <= 1'b0;
            refresh_active_q <= 1'b1;
            ref_cyc_q        <= '0;
          end else if (req_valid) begin
            mem_addr_q <= req_addr;
            if (req_write) begin
              mem_wdata_q <= req_wdata;
              mem_we_q    <= 1'b1;
              state_q     <= S_WR;
            end else begin
              state_q <= S_RD;
            end
          end
        end
        S_WR: begin
          mem_we_q <= 1'b0;
          state_q  <= S_IDLE;
        end
        S_RD: begin
          wait_cnt_q <= '0;
          state_q    <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (wait_cnt_q == WCNT_W'(RD_LAT - 1)) begin
            rsp_data_q  <= mem_rdata;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RSP;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        S_RSP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        S_REFRESH: begin
          if (ref_cyc_q == CCNT_W'(REFRESH_CYCLES - 1)) begin
            refresh_active_q <= 1'b0;
            state_q          <= S_IDLE;
          end else begin
            ref_cyc_q <= ref_cyc_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_host_initiator.sv
// Directed bench for dram_host_initiator with a 16x8 synchronous array model (1-cycle read latency).
module tb_dram_host_initiator;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_write_en;
  logic [DATA_W-1:0] mem_rdata;
  logic              refresh_active;

  logic [DATA_W-1:0] mem_arr [16];

  int ecnt;
  int checks;
  int errors;

  always #5 clk = ~clk;

  dram_host_initiator #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1),
    .REFRESH_PERIOD(64), .REFRESH_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write_en(mem_write_en),
    .mem_rdata(mem_rdata), .refresh_active(refresh_active)
  );

  // Array: write at the end of the write-enable cycle, registered read of the presented address.
  always @(posedge clk) begin
    if (mem_write_en) mem_arr[mem_addr] <= mem_wdata;
    mem_rdata <= mem_arr[mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
    ecnt++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int ref_cnt;
    int ref_rises;
    int first_ref;
    logic prev_ref;
    logic stall_bad;
    logic rsp_seen;

    checks = 0; errors = 0; ecnt = 0;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_ready", req_ready, 0);
    check("rst_we", mem_write_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_refresh", refresh_active, 0);
    rst = 1'b0;
    ecnt = 0;
    #1;
    check("post_rst_ready", req_ready, 1);

    // Write addr 3 = A5
    req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd3; req_wdata = 8'hA5;
    tick();                       // R1 accept
    req_valid = 1'b0;
    check("wr1_we", mem_write_en, 1);
    check("wr1_addr", mem_addr, 3);
    check("wr1_wdata", mem_wdata, 8'hA5);
    check("wr1_ready_low", req_ready, 0);
    check("wr1_no_rsp", rsp_valid, 0);
    tick();                       // R2
    check("wr1_we_drop", mem_write_en, 0);
    check("wr1_ready_back", req_ready, 1);
    check("wr1_addr_hold", mem_addr, 3);
    check("wr1_no_rsp2", rsp_valid, 0);

    // Write addr 7 = 5A, then read it back
    req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd7; req_wdata = 8'h5A;
    tick();                       // R3
    req_valid = 1'b0;
    check("wr2_we", mem_write_en, 1);
    tick();                       // R4
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd7; rsp_ready = 1'b1;
    tick();                       // R5 accept read
    req_valid = 1'b0;
    check("rd1_we", mem_write_en, 0);
    check("rd1_addr", mem_addr, 7);
    check("rd1_ready_low", req_ready, 0);
    check("rd1_no_rsp_yet", rsp_valid, 0);
    tick();                       // R6
    check("rd1_wait_no_rsp", rsp_valid, 0);
    tick();                       // R7
    check("rd1_rsp_valid", rsp_valid, 1);
    check("rd1_rsp_data", rsp_data, 8'h5A);
    check("rd1_rsp_ready_low", req_ready, 0);
    tick();                       // R8 handshake
    check("rd1_rsp_drop", rsp_valid, 0);
    check("rd1_ready_back", req_ready, 1);

    // Read addr 7 with backpressure
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd7; rsp_ready = 1'b0;
    tick();                       // R9 accept
    req_valid = 1'b0;
    tick();                       // R10
    tick();                       // R11
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_data", rsp_data, 8'h5A);
      check("bp_ready_low", req_ready, 0);
      if (i < 4) tick();
    end
    rsp_ready = 1'b1;
    tick();                       // R16 handshake
    check("bp_rsp_drop", rsp_valid, 0);
    check("bp_ready_back", req_ready, 1);

    // Continuous writes across the wrap at R64; accepts land on even edges
    tick();                       // R17
    req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd2; req_wdata = 8'h11;
    while (ecnt < 63) tick();
    check("wrap_pre_ready", req_ready, 1);
    tick();                       // R64: accept and wrap together
    check("wrap_inflight_we", mem_write_en, 1);
    check("wrap_inflight_addr", mem_addr, 2);
    check("wrap_no_ref_yet", refresh_active, 0);
    tick();                       // R65
    check("wrap_we_done", mem_write_en, 0);
    check("wrap_pending_ready", req_ready, 0);
    check("wrap_ref_not_yet", refresh_active, 0);
    ref_cnt = 0;
    stall_bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();                     // R66..R69
      if (refresh_active) ref_cnt++;
      if (mem_write_en || req_ready) stall_bad = 1'b1;
    end
    check("wrap_ref_len", ref_cnt, 4);
    check("wrap_ref_quiet", stall_bad, 0);
    tick();                       // R70
    check("wrap_ref_end", refresh_active, 0);
    check("wrap_resume_ready", req_ready, 1);
    tick();                       // R71
    check("wrap_resume_we", mem_write_en, 1);
    req_valid = 1'b0;
    tick();                       // R72

    // Long RSP stall spanning wraps at R128 and R192
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd3; rsp_ready = 1'b0;
    tick();                       // R73
    req_valid = 1'b0;
    tick();                       // R74
    tick();                       // R75
    check("stall_rsp_valid", rsp_valid, 1);
    check("stall_rsp_data", rsp_data, 8'hA5);
    stall_bad = 1'b0;
    for (int i = 0; i < 140; i++) begin
      tick();
      if (!rsp_valid || refresh_active || req_ready || rsp_data != 8'hA5) stall_bad = 1'b1;
    end
    check("stall_hold", stall_bad, 0);
    rsp_ready = 1'b1;
    tick();                       // R216
    check("stall_rsp_drop", rsp_valid, 0);
    check("stall_pending_ready", req_ready, 0);
    ref_cnt = 0; ref_rises = 0; prev_ref = refresh_active;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (refresh_active) ref_cnt++;
      if (refresh_active && !prev_ref) ref_rises++;
      prev_ref = refresh_active;
    end
    check("stall_ref_cycles", ref_cnt, 4);
    check("stall_ref_windows", ref_rises, 1);
    check("stall_ready_after", req_ready, 1);

    // Reset during RD_WAIT
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd7;
    tick();                       // accept
    req_valid = 1'b0;
    tick();                       // RD_WAIT
    check("abort_pre_rsp", rsp_valid, 0);
    rst = 1'b1;
    tick();
    check("abort_addr", mem_addr, 0);
    check("abort_wdata", mem_wdata, 0);
    check("abort_rsp_data", rsp_data, 0);
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_ready", req_ready, 0);
    rst = 1'b0;
    ecnt = 0;
    #1;
    check("abort_idle_ready", req_ready, 1);
    first_ref = -1;
    rsp_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (rsp_valid) rsp_seen = 1'b1;
      if (refresh_active && first_ref < 0) first_ref = ecnt;
    end
    check("abort_no_rsp", rsp_seen, 0);
    check("abort_first_ref_edge", first_ref, 65);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dram_host_initiator.md
Name: dram_host_initiator

Overview:
- Host-side initiator for the 16x8 simple DRAM array.
- Accepts single-beat read/write requests over a valid/ready handshake and drives the array's addr/wdata/write_en pins.
- Captures read data after a fixed array latency and returns it on a response channel with backpressure.
- Inserts periodic refresh windows, during which the array is not accessed and no requests are accepted.

Parameters:
- ADDR_W, 4, array address width (16 words)
- DATA_W, 8, data width
- RD_LAT, 1, array read latency in cycles from address-present cycle to valid mem_rdata (legal range 1..4)
- REFRESH_PERIOD, 64, cycles between refresh requests (legal minimum 8)
- REFRESH_CYCLES, 4, length of a refresh window in cycles (legal minimum 1)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous reset, active-high
- req_valid  input  1  host request present
- req_ready  output  1  initiator can accept a request
- req_write  input  1  1 = write, 0 = read
- req_addr  input  ADDR_W  request address
- req_wdata  input  DATA_W  write data
- rsp_valid  output  1  read data valid
- rsp_ready  input  1  host accepts read data
- rsp_data  output  DATA_W  read data
- mem_addr  output  ADDR_W  to array addr
- mem_wdata  output  DATA_W  to array wdata
- mem_write_en  output  1  to array write_en (1 = write, 0 = read)
- mem_rdata  input  DATA_W  from array rdata
- refresh_active  output  1  high throughout a refresh window

Behaviour:
- Reset: sync, active-high, clk only.
  - State IDLE; mem_addr, mem_wdata, rsp_data = 0; mem_write_en, rsp_valid, refresh_active = 0.
  - Refresh counter and refresh-pending flag = 0.
  - req_ready = 0 while rst = 1.
  - Reset mid-operation aborts any access and any refresh; no response is issued for the aborted request.
- States: IDLE, WR, RD, RD_WAIT, RSP, REFRESH. All mem_* outputs are registered.
- req_ready = (state == IDLE) && !ref_pending. It must not depend on req_valid.
- Accept: req_valid && req_ready at a rising edge. req_addr/req_wdata/req_write are latched.
- Write:
  - IDLE -> WR. For one cycle, mem_write_en = 1 and mem_addr/mem_wdata = latched values.
  - The array updates at the end of WR. Then WR -> IDLE.
  - Writes are posted: no response.
  - Peak rate is 1 write per 2 cycles.
- Read:
  - IDLE -> RD for one cycle: mem_addr = latched address, mem_write_en = 0.
  - RD -> RD_WAIT for RD_LAT cycles. mem_addr is held and mem_write_en stays 0.
  - On the last RD_WAIT edge, rsp_data <= mem_rdata and rsp_valid <= 1, state -> RSP.
  - With RD_LAT = 1, rsp_valid rises 2 edges after the accept edge.
- RSP:
  - rsp_valid and rsp_data are held stable until rsp_ready = 1 at an edge.
  - On that edge rsp_valid <= 0 and state -> IDLE.
  - req_ready = 0 throughout RSP.
- mem_write_en is 0 in every state except WR. mem_addr/mem_wdata keep their last values outside WR/RD/RD_WAIT.
- Refresh:
  - The free-running counter counts 0..REFRESH_PERIOD-1 and wraps.
  - On wrap, ref_pending <= 1.
  - If ref_pending is already 1, it stays 1. A second wrap is not queued (at most one outstanding refresh).
- Refresh priority:
  - In IDLE with ref_pending = 1, the next state is REFRESH, regardless of req_valid.
  - On entering REFRESH, ref_pending is cleared. refresh_active = 1 and mem_write_en = 0 for exactly REFRESH_CYCLES cycles, then the state returns to IDLE.
  - A pending refresh never preempts WR/RD/RD_WAIT/RSP. It waits for IDLE.
- Same-edge events:
  - If the counter wraps on the same edge that a request is accepted, the request proceeds and the refresh follows it.
  - A write followed by a read to the same address returns the new data.

Test Plan:
- Reset, then write addr 3 = 0xA5 -> mem_write_en high exactly 1 cycle with mem_addr = 3, mem_wdata = 0xA5; req_ready low that cycle, high next; no rsp_valid.
- Write 0x5A to addr 7, then read addr 7 with rsp_ready = 1 -> rsp_valid rises 2 edges after read accept with rsp_data = 0x5A, for 1 cycle.
- Read addr 7 with rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_data = 0x5A stable for all 5 cycles, req_ready = 0 throughout; handshake on cycle 6 drops rsp_valid and restores req_ready.
- Hold req_valid high continuously across a counter wrap (period 64) -> in-flight request completes, then refresh_active = 1 for 4 cycles with mem_write_en = 0 and req_ready = 0, then requests resume.
- Stall in RSP (rsp_ready = 0) for 140 cycles, spanning two wraps -> exactly one 4-cycle refresh window after RSP exits.
- Assert rst during RD_WAIT of a read -> next cycle all outputs are 0 and the state is IDLE; no rsp_valid; first refresh occurs 64 cycles after reset release.
